// File: rtl/relu_pkg.sv
// Shared types and width defaults for the masked dot-product / relu pipeline.
package relu_pkg;
  localparam int N_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/dot_acc_if.sv
// Beat-in / result-out handshake bundle for dot_acc.
// A transfer happens on a rising edge where valid && ready; the sender holds
// valid and its data stable until that edge, and valid never waits on ready.
interface dot_acc_if #(parameter int N = relu_pkg::N_DEF);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] w;
  logic [N-1:0] a;
  logic [N-1:0] bias;
  logic [N-1:0] mask;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] o;

  modport master (
    output in_valid, w, a, bias, mask, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, w, a, bias, mask, out_ready,
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/mul_lo.sv
// Combinational N x N multiplier keeping only the low N bits (mod 2^N).
module mul_lo #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] p
);
  assign p = x * y;
endmodule

// File: rtl/dot_acc.sv
// Accumulates K (w*a) products plus bias mod 2^N, then emits (sum - mask) as
// the evaluator's masked share for the downstream relu stage.
module dot_acc
  import relu_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = 8
) (
  input  logic       clk,
  input  logic       rst,
  dot_acc_if.slave   bus,
  output state_t     state_dbg
);
  // One extra bit so K a power of two never wraps the beat counter.
  localparam int CW = $clog2(K) + 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [N-1:0]  acc, acc_nx;
  logic [N-1:0]  mask_q, mask_nx;
  logic [N-1:0]  o_q;
  logic [N-1:0]  prod;
  logic          in_ready;
  logic          out_valid;

  mul_lo #(.N(N)) u_mul (
    .x (bus.w),
    .y (bus.a),
    .p (prod)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    acc_nx    = acc;
    mask_nx   = mask_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_nx   = bus.bias + prod;
          mask_nx  = bus.mask;
          cnt_nx   = CW'(1);
          state_nx = (K == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_nx = acc + prod;
          cnt_nx = cnt + 1'b1;
          if (cnt == CW'(K - 1)) state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mask_q <= '0;
      o_q    <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      acc    <= acc_nx;
      mask_q <= mask_nx;
      // Result register loads only on entry to DONE, so it holds under backpressure.
      if (state != DONE && state_nx == DONE) o_q <= acc_nx - mask_nx;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.o         = o_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_dot_acc.sv
// Directed-vector bench for dot_acc: K=4 instance for the main scenarios and a
// K=1 instance for the single-beat case.
module tb_dot_acc;
  import relu_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t st4;
  state_t st1;

  int n_checks = 0;
  int n_bad    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wv[4];
  logic [31:0] av[4];

  dot_acc_if #(.N(32)) bus  ();
  dot_acc_if #(.N(32)) bus1 ();

  dot_acc #(.N(32), .K(4)) u_dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus.slave),
    .state_dbg (st4)
  );

  dot_acc #(.N(32), .K(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus1.slave),
    .state_dbg (st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // drive one beat, present for exactly one rising edge
  task automatic beat(input logic [31:0] wi, input logic [31:0] ai,
                      input logic [31:0] bi, input logic [31:0] mi);
    bus.in_valid = 1'b1;
    bus.w        = wi;
    bus.a        = ai;
    bus.bias     = bi;
    bus.mask     = mi;
    check("in_ready_beat", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // send wv/av as one vector; bias/mask of beat 0 differ from later beats
  task automatic run_vec(input string tag, input int gap,
                         input logic [31:0] b0, input logic [31:0] m0,
                         input logic [31:0] bl, input logic [31:0] ml,
                         input logic [31:0] exp_o);
    exp_q.push_back(exp_o);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      if (i == 3) check({tag, "_ov_early"}, 32'(bus.out_valid), 32'd0);
      beat(wv[i], av[i], (i == 0) ? b0 : bl, (i == 0) ? m0 : ml);
    end
    check({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_st"}, 32'(st4), 32'(DONE));
    check({tag, "_o"}, bus.o, exp_q.pop_front());
  endtask

  task automatic load_basic();
    wv[0] = 1; wv[1] = 2; wv[2] = 3; wv[3] = 4;
    av[0] = 5; av[1] = 6; av[2] = 7; av[3] = 8;
  endtask

  initial begin
    bus.in_valid = 0; bus.w = 0; bus.a = 0; bus.bias = 0; bus.mask = 0; bus.out_ready = 0;
    bus1.in_valid = 0; bus1.w = 0; bus1.a = 0; bus1.bias = 0; bus1.mask = 0; bus1.out_ready = 0;
    rst_n = 1'b0;
    #12;
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    check("rst_o", bus.o, 32'd0);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    check("rst_st", 32'(st4), 32'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // basic: 10 + 5+12+21+32 - 3 = 77
    bus.out_ready = 1'b1;
    load_basic();
    run_vec("basic", 0, 32'd10, 32'd3, 32'd10, 32'd3, 32'd77);
    @(posedge clk); #1;
    check("basic_ov_drop", 32'(bus.out_valid), 32'd0);
    check("basic_idle", 32'(st4), 32'(IDLE));

    // wrap: 0xFFFFFFFF*2 = 0xFFFFFFFE, minus 1
    wv[0] = 32'hFFFF_FFFF; wv[1] = 0; wv[2] = 0; wv[3] = 0;
    av[0] = 2;             av[1] = 0; av[2] = 0; av[3] = 0;
    run_vec("wrap", 0, 32'd0, 32'd1, 32'd0, 32'd1, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    av[0] = 0; wv[0] = 0;
    run_vec("zero", 0, 32'd0, 32'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // bubbles with junk bias/mask on later beats
    load_basic();
    run_vec("bubble", 3, 32'd10, 32'd3, 32'd99, 32'd99, 32'd77);
    @(posedge clk); #1;

    // backpressure with a held upstream beat (becomes beat 0 of the next vector)
    bus.out_ready = 1'b0;
    run_vec("bp", 0, 32'd10, 32'd3, 32'd10, 32'd3, 32'd77);
    bus.in_valid = 1'b1; bus.w = 2; bus.a = 3; bus.bias = 1; bus.mask = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_o_hold", bus.o, 32'd77);
      check("bp_rdy", 32'(bus.in_ready), 32'd0);
      check("bp_ov", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle", 32'(st4), 32'(IDLE));
    check("bp_ov_drop", 32'(bus.out_valid), 32'd0);
    // held beat: 1 + 2*3 = 7; then three 1*1 beats with ignored bias/mask -> 10
    beat(32'd2, 32'd3, 32'd1, 32'd0);
    beat(32'd1, 32'd1, 32'd50, 32'd50);
    beat(32'd1, 32'd1, 32'd50, 32'd50);
    beat(32'd1, 32'd1, 32'd50, 32'd50);
    check("bp_next_ov", 32'(bus.out_valid), 32'd1);
    check("bp_next_o", bus.o, 32'd10);
    @(posedge clk); #1;

    // reset mid-vector, asserted between edges
    beat(32'd1, 32'd5, 32'd10, 32'd3);
    beat(32'd2, 32'd6, 32'd99, 32'd99);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_o", bus.o, 32'd0);
    check("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    check("mid_rst_st", 32'(st4), 32'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load_basic();
    run_vec("post_rst", 0, 32'd10, 32'd3, 32'd10, 32'd3, 32'd77);
    @(posedge clk); #1;

    // K=1: 1 + 6*7 - 0 = 43
    bus1.out_ready = 1'b1;
    bus1.in_valid = 1'b1; bus1.w = 6; bus1.a = 7; bus1.bias = 1; bus1.mask = 0;
    check("k1_rdy", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    check("k1_st", 32'(st1), 32'(DONE));
    check("k1_ov", 32'(bus1.out_valid), 32'd1);
    check("k1_o", bus1.o, 32'd43);
    @(posedge clk); #1;
    check("k1_ov_drop", 32'(bus1.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/dot_acc.md
# dot_acc

Sequential share-domain dot-product stage that sits directly upstream of the relu block. It accepts one (weight, activation) pair per handshake beat and accumulates K products plus a bias modulo 2^N. It then subtracts the garbler's mask r1 and presents the result as the evaluator's masked value x − r1, which the relu block consumes as its `e_input`. Arithmetic is purely modular, with no saturation or overflow flag, so it stays consistent with the additive-share reconstruction downstream.

## Interface
- N, 32, operand/result bit-width; all arithmetic is mod 2^N.
- K, 8, vector length (beats per result); K ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  beat valid.
- in_ready  output  1  stage can accept a beat.
- w  input  N  weight element i.
- a  input  N  activation element i.
- bias  input  N  bias; sampled only on beat 0 of a vector.
- mask  input  N  r1 mask; sampled only on beat 0 of a vector.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- o  output  N  (bias + Σ w_i·a_i − mask) mod 2^N.

## Operation
- States: IDLE, ACC, DONE.
- A beat is accepted when in_valid && in_ready.
- IDLE: in_ready=1. On an accepted beat:
  - acc ← bias + lo_N(w·a).
  - mask_q ← mask.
  - cnt ← 1.
  - Next state: ACC, or DONE if K=1.
- ACC: in_ready=1. On an accepted beat:
  - acc ← acc + lo_N(w·a).
  - cnt ← cnt+1.
  - If cnt == K−1 on that beat: next state DONE.
  - in_valid low: hold all state; bubbles are allowed without limit.
- DONE: in_ready=0, out_valid=1, o = acc − mask_q (registered).
  - o holds stable while out_ready=0.
  - On out_ready=1: next state IDLE, out_valid drops the following cycle.
- Products: only the low N bits of the N×N product are kept (two's-complement correct mod 2^N). Sums wrap mod 2^N.
- bias and mask are ignored on beats 1..K−1.
- Inputs and outputs never overlap: no new vector is accepted in DONE.
- cnt is $clog2(K)+1 bits wide so that K a power of two does not alias.

## Timing
- Reset values (asynchronous, while rst=0):
  - state=IDLE, cnt=0, acc=0, mask_q=0.
  - in_ready=1 (combinational from IDLE), out_valid=0, o=0.
- Latency: out_valid rises on the cycle after the K-th accepted beat.
- Throughput: K+1 cycles per vector minimum, because the DONE→IDLE handoff takes one cycle.
- o is registered and changes only on entry to DONE; it is unchanged while out_valid && !out_ready.
- in_ready depends only on state, never combinationally on out_ready.
- Reset mid-vector or in DONE: the partial sum is discarded and the state returns to IDLE. The next accepted beat is treated as beat 0.
- When in_valid is asserted in DONE, the beat is not accepted. The upstream must hold it (standard valid/ready rule).

## Structure
- Package `relu_pkg`:
  - state enum {IDLE, ACC, DONE}.
  - default width constant N=32, shared with relu.
- Sub-module `mul_lo`: combinational N×N → low-N multiplier, parameterised on N. It is kept separate so the garbled-circuit synthesis flow can swap in an optimised multiplier netlist.
- The rest (FSM, counter, accumulator, mask subtract, output register) lives in dot_acc.

## Test plan
- Basic, N=32, K=4:
  - Stimulus: w=[1,2,3,4], a=[5,6,7,8], bias=10, mask=3, back-to-back beats, out_ready=1.
  - Required: o=77, out_valid exactly one cycle after the 4th beat.
- Wrap:
  - Stimulus: w0=0xFFFFFFFF, a0=2, other pairs 0, bias=0, mask=1.
  - Required: o=0xFFFFFFFD.
  - Also: all-zero vector with mask=1 gives o=0xFFFFFFFF.
- Bubbles and late sampling:
  - Stimulus: basic vector with in_valid low 3 cycles between beats; bias=99 and mask=99 driven on beats 1–3.
  - Required: o=77 still, because bias and mask are sampled only on beat 0.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DONE while in_valid stays high.
  - Required: o stable at 77, in_ready=0, no beat consumed.
  - Then out_ready=1: IDLE next cycle, and the next vector is computed correctly.
- Reset mid-vector:
  - Stimulus: assert rst after 2 beats, asynchronously between edges.
  - Required: out_valid=0 and o=0 immediately.
  - A fresh basic vector afterwards yields o=77.
- K=1:
  - Stimulus: w=6, a=7, bias=1, mask=0.
  - Required: DONE after a single beat, o=43.
